mlm_ecc_pipe: RTL
=================

# mlm_ecc_pipe

Parametrised, pipelined SEC-DED (Hamming plus overall parity) checker/corrector with an encode bypass mode. It generalises the fixed 16-bit/5-bit parity generator to any data width and adds correction, valid/ready flow control and saturating error counters. It sits between a storage or transport stage and its consumer.

## Interface
- DATA_W, 16, data width (≥4)
- CNT_W, 8, error counter width
- P_W (localparam), smallest p with 2^p ≥ DATA_W+p+1 (5 for DATA_W=16); check width C_W = P_W+1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_valid / i_ready  in / out  1  input handshake
- i_enc  in  1  1 = encode beat (no check), 0 = check/correct beat
- i_data  in  DATA_W  received data
- i_chk  in  C_W  received check; [P_W-1:0] Hamming bits, [P_W] overall parity
- o_valid / o_ready  out / in  1  output handshake
- o_data  out  DATA_W  corrected (or passed) data
- o_chk  out  C_W  check bits recomputed from o_data
- o_syn  out  P_W  syndrome
- o_sec / o_ded  out  1  single corrected / double detected
- i_clr  in  1  synchronous counter clear
- sec_cnt / ded_cnt  out  CNT_W  saturating event counts

## Operation
- Codeword positions 1..N, N = DATA_W+P_W. Check bit k sits at position 2^k. Data bit d (i_data[d]) takes the d-th non-power-of-two position, ascending: d0→3, d1→5, d2→6, d3→7, d4→9, and so on.
- Hamming bit k = XOR of the data bits whose position has bit k set. Overall bit = XOR of all data and Hamming bits (even parity).
- Check beat:
  - Syndrome s = recomputed Hamming XOR i_chk[P_W-1:0].
  - Parity q = XOR of i_data and all of i_chk.
  - q=0, s=0: clean.
  - q=1, s=0: overall bit in error; o_sec=1, data unchanged.
  - q=1, 1≤s≤N: o_sec=1. If s is a data position, flip that data bit; if it is a check position, data unchanged.
  - q=1, s>N: o_ded=1, data passed unchanged.
  - q=0, s≠0: o_ded=1, data passed unchanged.
- Encode beat: o_data=i_data, o_syn=0, o_sec=o_ded=0.
- o_chk is always the encoding of o_data.
- Counters:
  - Increment only on an output handshake (o_valid & o_ready) carrying o_sec or o_ded.
  - Saturate at all-ones.
  - If i_clr is asserted, the count is 0 that cycle, including when an increment coincides.

## Timing
- Two register stages. S1 captures the inputs, s and q. S2 holds the corrected outputs.
- Latency is 2 cycles from input handshake to o_valid when o_ready is held high. Sustained throughput is 1 beat/cycle.
- A stage loads when it is empty or its contents advance in the same cycle. i_ready = !s1_valid | s1_advance (combinational from o_ready through at most two stages).
- While o_valid & !o_ready, all outputs hold stable and i_ready falls once S1 is also full.
- Reset values: o_valid=0, i_ready=1, o_data=0, o_chk=0, o_syn=0, o_sec=0, o_ded=0, sec_cnt=0, ded_cnt=0.
- Reset mid-stream discards both stages; no beat is output after reset release without a new input.
- Counter values are visible the cycle after the counted handshake.

## Structure
- Package mlm_ecc_pkg holds:
  - the function computing P_W from DATA_W;
  - the position-mapping function (data index → position);
  - the encode function (data → C_W check).
- Sub-module mlm_ecc_enc is the combinational encoder. It is instantiated twice: once in S1 to recompute check bits for the syndrome, once in S2 for o_chk.

## Test plan
All cases use DATA_W=16.
- Check beat, data 16'h0000, chk 0 → o_data=16'h0000, o_syn=0, o_sec=0, o_ded=0, 2-cycle latency.
- Data 16'h0008 (d3 flipped), chk 0 → o_data=16'h0000, o_syn=7, o_sec=1, sec_cnt=1.
- Data 16'h0003, chk 0 → o_syn=6, o_ded=1, o_data=16'h0003, ded_cnt=1.
- Chk 6'b100000, data 0 → o_sec=1, o_syn=0, o_data=0. Then an encode beat with data 16'hdead → o_chk equals the package encode of 16'hdead and no flags.
- Throughput and backpressure:
  - 100 back-to-back beats with o_ready toggling randomly → order preserved, outputs stable while stalled.
  - 300 single-error beats → sec_cnt saturates at 255; i_clr → 0.
- Reset asserted with both stages full → o_valid=0 immediately and counters 0. No stale beat appears after release.

Source files
------------

// File: rtl/mlm_ecc_pkg.sv
// Shared SEC-DED helpers: check-width sizing, codeword position map and encoder.
package mlm_ecc_pkg;

  // Widest data word the helper functions accept, and its check width.
  localparam int MAX_DW = 64;
  localparam int MAX_CW = 8;

  // Smallest p with 2^p >= dw + p + 1.
  function automatic int calc_pw(input int dw);
    int p;
    p = 0;
    while ((1 << p) < dw + p + 1) p++;
    return p;
  endfunction

  // Codeword position of data bit d: the d-th position that is not a power of two.
  function automatic int data_pos(input int d);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 3; p < 2 * MAX_DW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == d && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Check bits for the low dw bits of data: Hamming bits in [pw-1:0], even overall parity in [pw].
  function automatic logic [MAX_CW-1:0] ecc_encode(input logic [MAX_DW-1:0] data, input int dw);
    logic [MAX_CW-1:0] chk;
    logic              par;
    int                pw;
    chk = '0;
    par = 1'b0;
    pw  = calc_pw(dw);
    // Each set data bit toggles exactly the Hamming bits named by its position.
    for (int d = 0; d < MAX_DW; d++) begin
      if (d < dw && data[d]) begin
        chk = chk ^ MAX_CW'(data_pos(d));
        par = ~par;
      end
    end
    par = par ^ (^chk);
    chk = chk | (MAX_CW'(par) << pw);
    return chk;
  endfunction

endpackage

// File: rtl/mlm_ecc_enc.sv
// Combinational SEC-DED encoder: data -> Hamming bits plus overall parity.
module mlm_ecc_enc
  import mlm_ecc_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int C_W = calc_pw(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] data,
  output logic [C_W-1:0]    chk
);

  assign chk = C_W'(ecc_encode(MAX_DW'(data), DATA_W));

endmodule

// File: rtl/mlm_ecc_pipe.sv
// Two-stage SEC-DED checker/corrector with encode bypass, valid/ready flow
// control and saturating single/double error counters.
module mlm_ecc_pipe
  import mlm_ecc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8,
  localparam int P_W = calc_pw(DATA_W),
  localparam int C_W = P_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic              i_enc,
  input  logic [DATA_W-1:0] i_data,
  input  logic [C_W-1:0]    i_chk,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [C_W-1:0]    o_chk,
  output logic [P_W-1:0]    o_syn,
  output logic              o_sec,
  output logic              o_ded,
  input  logic              i_clr,
  output logic [CNT_W-1:0]  sec_cnt,
  output logic [CNT_W-1:0]  ded_cnt
);

  localparam int N_POS = DATA_W + P_W;

  logic [C_W-1:0]    chk_p0;
  logic [P_W-1:0]    syn_p0;
  logic              par_p0;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [P_W-1:0]    syn_p1;
  logic              par_p1;

  logic              s2_load;
  logic              adv_p1;
  int                syn_int;
  logic [DATA_W-1:0] data_c;
  logic              sec_c;
  logic              ded_c;

  // ---- Stage 0: syndrome and received-codeword parity from the raw inputs
  mlm_ecc_enc #(.DATA_W(DATA_W)) u_enc_p0 (.data(i_data), .chk(chk_p0));

  assign syn_p0 = chk_p0[P_W-1:0] ^ i_chk[P_W-1:0];
  // Parity of {i_data, i_chk}: recomputed overall bit folds in the data and
  // recomputed Hamming bits, the syndrome swaps those for the received ones.
  assign par_p0 = chk_p0[P_W] ^ (^syn_p0) ^ i_chk[P_W];

  // Flow control: a stage loads when empty or when its contents move on.
  assign s2_load = !o_valid || o_ready;
  assign adv_p1  = vld_p1 && s2_load;
  assign i_ready = !vld_p1 || adv_p1;

  // ---- Stage 1 boundary
  // S1 occupancy follows the input handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else if (i_ready) vld_p1 <= i_valid;
  end

  // S1 payload; an encode beat is stored as clean so it passes untouched.
  always_ff @(posedge clk) begin
    if (i_valid && i_ready) begin
      data_p1 <= i_data;
      syn_p1  <= i_enc ? '0 : syn_p0;
      par_p1  <= i_enc ? 1'b0 : par_p0;
    end
  end

  assign syn_int = int'(syn_p1);

  // Classify the beat and flip the data bit named by a single-error syndrome.
  always_comb begin
    data_c = data_p1;
    sec_c  = 1'b0;
    ded_c  = 1'b0;
    if (par_p1) begin
      if (syn_int <= N_POS) begin
        sec_c = 1'b1;
        for (int d = 0; d < DATA_W; d++) begin
          if (data_pos(d) == syn_int) data_c[d] = ~data_p1[d];
        end
      end else begin
        ded_c = 1'b1;
      end
    end else if (syn_int != 0) begin
      ded_c = 1'b1;
    end
  end

  // ---- Stage 2 boundary
  // Output register; contents hold while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_syn   <= '0;
      o_sec   <= 1'b0;
      o_ded   <= 1'b0;
    end else begin
      if (s2_load) o_valid <= vld_p1;
      if (adv_p1) begin
        o_data <= data_c;
        o_syn  <= syn_p1;
        o_sec  <= sec_c;
        o_ded  <= ded_c;
      end
    end
  end

  mlm_ecc_enc #(.DATA_W(DATA_W)) u_enc_p2 (.data(o_data), .chk(o_chk));

  // Saturating event counters, stepped only by delivered flagged beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (i_clr) begin
      sec_cnt <= '0;
      ded_cnt <= '0;
    end else if (o_valid && o_ready) begin
      if (o_sec && sec_cnt != '1) sec_cnt <= sec_cnt + 1'b1;
      if (o_ded && ded_cnt != '1) ded_cnt <= ded_cnt + 1'b1;
    end
  end

endmodule
